// File: rtl/shiftreg_word_serializer_if.sv
// Word-in / serial-out bundle between the shift register, the serializer and its consumer.
// The master modport is the upstream word source and downstream monitor; the slave modport is the serializer.
interface shiftreg_word_serializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] word_in;
    logic             dir_in;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_last;
    logic             busy;

    modport master (
        output word_in, dir_in, in_valid,
        input  in_ready, ser_out, ser_valid, frame_start, frame_last, busy
    );

    modport slave (
        input  word_in, dir_in, in_valid,
        output in_ready, ser_out, ser_valid, frame_start, frame_last, busy
    );
endinterface

// File: rtl/shiftreg_word_serializer.sv
// Serializes WIDTH-bit words, MSB- or LSB-first per word, with a one-entry pending buffer
// so the next word can be accepted while the current frame shifts out.
module shiftreg_word_serializer #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned GAP_CYCLES = 0
) (
    input logic                       clk,
    input logic                       rst,
    shiftreg_word_serializer_if.slave bus
);
    localparam int unsigned BW       = $clog2(WIDTH);
    localparam int unsigned GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             dir_q;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [WIDTH-1:0] pend_word;
    logic             pend_dir;
    logic             pend_full;
    logic             ready_q;
    logic             ser_out_q;
    logic             ser_valid_q;
    logic             frame_start_q;
    logic             frame_last_q;
    logic             busy_q;

    logic accept_c;
    logic last_bit_c;
    logic gap_done_c;
    logic load_c;
    logic pend_next_c;

    function automatic logic out_bit(input logic [WIDTH-1:0] w, input logic d);
        return d ? w[0] : w[WIDTH-1];
    endfunction

    // Move the next bit into the output position for the word's bit order.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w, input logic d);
        return d ? (w >> 1) : (w << 1);
    endfunction

    always_comb begin
        accept_c    = bus.in_valid && ready_q;
        last_bit_c  = (state == SHIFT) && (bit_cnt == BW'(WIDTH - 1));
        gap_done_c  = (state == GAP) && (gap_cnt == GW'(GAP_LAST));
        load_c      = pend_full && ((state == IDLE) || (last_bit_c && (GAP_CYCLES == 0)) || gap_done_c);
        pend_next_c = accept_c || (pend_full && !load_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            shreg         <= '0;
            dir_q         <= 1'b0;
            bit_cnt       <= '0;
            gap_cnt       <= '0;
            pend_word     <= '0;
            pend_dir      <= 1'b0;
            pend_full     <= 1'b0;
            ready_q       <= 1'b1;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            pend_full     <= pend_next_c;
            ready_q       <= !pend_next_c;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
            if (accept_c) begin
                pend_word <= bus.word_in;
                pend_dir  <= bus.dir_in;
            end
            if (load_c) begin
                // Loading presents bit 0 right away, so a frame follows the previous one without a bubble.
                state         <= SHIFT;
                shreg         <= pend_word;
                dir_q         <= pend_dir;
                bit_cnt       <= '0;
                ser_valid_q   <= 1'b1;
                ser_out_q     <= out_bit(pend_word, pend_dir);
                frame_start_q <= 1'b1;
                busy_q        <= 1'b1;
            end else begin
                case (state)
                    IDLE: busy_q <= pend_next_c;
                    SHIFT: begin
                        if (last_bit_c) begin
                            state   <= (GAP_CYCLES != 0) ? GAP : IDLE;
                            gap_cnt <= '0;
                            busy_q  <= (GAP_CYCLES != 0) || pend_next_c;
                        end else begin
                            shreg        <= shift_word(shreg, dir_q);
                            bit_cnt      <= bit_cnt + BW'(1);
                            ser_valid_q  <= 1'b1;
                            ser_out_q    <= out_bit(shift_word(shreg, dir_q), dir_q);
                            frame_last_q <= (bit_cnt == BW'(WIDTH - 2));
                            busy_q       <= 1'b1;
                        end
                    end
                    GAP: begin
                        if (gap_done_c) begin
                            state  <= IDLE;
                            busy_q <= pend_next_c;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                            busy_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= pend_next_c;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready    = ready_q;
    assign bus.ser_out     = ser_out_q;
    assign bus.ser_valid   = ser_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_last  = frame_last_q;
    assign bus.busy        = busy_q;
endmodule

// File: doc/shiftreg_word_serializer.md
Name: shiftreg_word_serializer

Overview:
Downstream stage of the 4-bit universal shift register. Accepts its parallel output word, p_dout, through a valid/ready handshake and streams it out one bit per clock, MSB-first or LSB-first as selected per word. A one-entry pending buffer lets the next word be accepted while the current frame is shifting, giving gap-free back-to-back frames.

Parameters:
WIDTH, 4, word width in bits (must be >= 2)
GAP_CYCLES, 0, idle cycles inserted between consecutive frames (0 = continuous stream)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
word_in  input  WIDTH  parallel word (connects to shift register p_dout)
dir_in  input  1  bit order for word_in: 0 = MSB first, 1 = LSB first
in_valid  input  1  word_in/dir_in valid
in_ready  output  1  pending buffer empty; word accepted when in_valid && in_ready at rising clk
ser_out  output  1  serial data bit
ser_valid  output  1  ser_out carries a frame bit this cycle
frame_start  output  1  high with the first bit of each frame
frame_last  output  1  high with the last bit of each frame
busy  output  1  high when state != IDLE or the pending buffer is full

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately):
  - state = IDLE; pending buffer emptied; shift register and bit counter cleared.
  - ser_out, ser_valid, frame_start, frame_last and busy = 0; in_ready = 1.
- Reset mid-frame aborts the frame and discards the pending word; no partial bits follow release.
- in_ready is registered and equals !pend_full (no combinational in_valid-to-in_ready path).
- Accept edge: word_in and dir_in are captured into the pending buffer and pend_full is set.
- State machine IDLE / SHIFT / GAP:
  - IDLE: if pend_full at an edge, load the shift register from pending, clear pend_full, go to SHIFT with bit_cnt = 0.
  - SHIFT: one bit per cycle. ser_valid = 1. ser_out = shreg[WIDTH-1] when dir = 0, shreg[0] when dir = 1. Shift by one toward the output at each edge; bit_cnt increments.
  - SHIFT, at the edge ending bit WIDTH-1:
    - If GAP_CYCLES = 0 and pend_full: load the next word at that edge and stay in SHIFT (no bubble).
    - If GAP_CYCLES = 0 and not pend_full: go to IDLE.
    - If GAP_CYCLES > 0: go to GAP with gap_cnt = 0.
  - GAP: ser_valid = 0 for exactly GAP_CYCLES cycles. On the final gap edge, load the next word (-> SHIFT) if pend_full, else go to IDLE.
- Latency: a word accepted at edge k is loaded at edge k+1. Bit i is valid in the cycle after edge k+1+i (outputs registered).
- frame_start = 1 while bit_cnt = 0 in SHIFT; frame_last = 1 while bit_cnt = WIDTH-1 in SHIFT.
- ser_out = 0 whenever ser_valid = 0.
- Simultaneous load and accept at one edge: the load empties pending and the accept refills it. Legal only if in_ready was 1, so no overwrite can occur.
- in_valid while in_ready = 0: ignored; the upstream stage must hold word_in until accepted.
- dir is latched per word; changing dir_in mid-frame has no effect on the current frame.
- bit_cnt width = clog2(WIDTH); gap_cnt width = clog2(GAP_CYCLES+1). Neither counter wraps outside its state.

Test Plan:
1. Assert rst low mid-sim with no clock edge -> all outputs 0 at once, in_ready = 1; after release, ser_valid stays 0 with no input.
2. WIDTH=4, word 4'b1101, dir 0, accepted at edge k -> ser_out 1,1,0,1 in cycles k+1..k+4; frame_start in the 1st cycle, frame_last in the 4th; ser_valid 0 from cycle k+5.
3. Same word with dir 1 -> ser_out 1,0,1,1; in_ready 0 for one cycle after accept, then 1.
4. GAP_CYCLES=0: accept 4'b1101 (dir 0), then 4'b0110 (dir 0) on the next ready -> 8 consecutive valid bits 1,1,0,1,0,1,1,0 with no bubble; frame_start on bits 1 and 5.
5. Backpressure: hold in_valid with a third word 4'b1001 while pending is full -> not accepted until in_ready rises; all three frames complete in order with the correct bits.
6. GAP_CYCLES=2 instance with back-to-back words -> exactly 2 cycles of ser_valid = 0 between frames. Also assert rst low during bit 2 of a frame -> outputs 0 immediately, pending word lost, no bits after release.
